vita49_framer: RTL and testbench

VITA49_FRAMER -- requirements
Module: vita49_framer

---
 rtl/vita49_framer_if.sv | 11 +
 rtl/vita49_framer.sv | 228 ++++++++++++++++++++++
 tb/tb_vita49_framer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vita49_framer_if.sv
// AXI4-Stream style handshake bundle carrying 32-bit words.
// The master drives data/valid/last, the slave drives ready.
interface vita49_framer_if;
    logic [31:0] TDATA;
    logic        TVALID;
    logic        TREADY;
    logic        TLAST;

    modport master (output TDATA, TVALID, TLAST, input TREADY);
    modport slave  (input TDATA, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/vita49_framer.sv
// VITA-49 signal data packet framer: prepends header, stream ID and
// timestamps to a sample stream and optionally appends a trailer word.
module vita49_framer #(
    parameter int TSI_EN = 1,
    parameter int TSF_EN = 1,
    parameter int TRL_EN = 0,
    parameter int CNT_W  = 32
) (
    input  logic               AXIS_ACLK,
    input  logic               AXIS_ARESETN,
    vita49_framer_if.slave     s_axis,
    vita49_framer_if.master    m_axis,
    input  logic [31:0]        ctrl,
    output logic [31:0]        status,
    input  logic [31:0]        streamID,
    input  logic [15:0]        pkt_size,
    input  logic [CNT_W-1:0]   words_to_pack,
    input  logic [31:0]        trailer_in,
    input  logic [31:0]        timestamp_sec,
    input  logic [63:0]        timestamp_fsec
);
    localparam int          H     = 2 + TSI_EN + 2 * TSF_EN;
    localparam logic [15:0] OVH   = 16'(H + TRL_EN);
    localparam logic [1:0]  TSI_F = (TSI_EN != 0) ? 2'b11 : 2'b00;
    localparam logic [1:0]  TSF_F = (TSF_EN != 0) ? 2'b01 : 2'b00;
    localparam logic        TRL_B = (TRL_EN != 0);
    localparam int          XW    = CNT_W + 16;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_SID, S_TSI, S_TSF0,
        S_TSF1, S_PAY, S_TRL, S_DONE
    } state_t;

    state_t            state_q;
    logic [31:0]       hold_q;
    logic              hold_v_q;
    logic              hold_l_q;
    logic [15:0]       pay_cnt_q;
    logic [15:0]       pay_lim_q;
    logic              last_pkt_q;
    logic [CNT_W-1:0]  words_sent_q;
    logic [3:0]        pkt_cnt_q;
    logic [7:0]        pkts_sent_q;
    logic              cfg_err_q;
    logic              stop_q;
    logic [31:0]       tsec_q;
    logic [63:0]       tfsec_q;
    logic [31:0]       trl_q;

    logic              start, rcmd, pass, stop;
    logic              busy, done;
    logic [15:0]       pay_max;
    logic [CNT_W-1:0]  rem;
    logic [XW-1:0]     rem_x, pay_max_x;
    logic              last_now;
    logic [15:0]       hdr_size;
    logic              pay_end;
    logic              m_vld, m_lst;
    logic [31:0]       m_dat;
    logic              m_fire, drain, s_rdy, s_fire;
    logic              pkt_stop;
    state_t            after_sid, after_tsi;
    logic              unused_ctrl;

    assign start       = ctrl[0];
    assign rcmd        = ctrl[1];
    assign pass        = ctrl[2];
    assign stop        = ctrl[3];
    assign unused_ctrl = ^ctrl[31:4];

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done = (state_q == S_DONE);

    // Final packet of a bounded run carries only the remaining words.
    assign pay_max   = pkt_size - OVH;
    assign rem       = words_to_pack - words_sent_q;
    assign rem_x     = XW'(rem);
    assign pay_max_x = XW'(pay_max);
    assign last_now  = (|words_to_pack) && (rem_x <= pay_max_x);
    assign hdr_size  = last_now ? (OVH + 16'(rem)) : pkt_size;
    assign pay_end   = ((pay_cnt_q + 16'd1) == pay_lim_q);
    assign pkt_stop  = last_pkt_q || stop_q || stop;

    assign after_tsi = (TSF_EN != 0) ? S_TSF0 : S_PAY;
    assign after_sid = (TSI_EN != 0) ? S_TSI : after_tsi;

    always_comb begin
        m_vld = 1'b0;
        m_dat = '0;
        m_lst = 1'b0;
        if (pass) begin
            m_vld = hold_v_q;
            m_dat = hold_q;
            m_lst = hold_l_q;
        end else begin
            unique case (state_q)
                S_HDR: begin
                    m_vld = 1'b1;
                    m_dat = {4'b0001, 1'b0, TRL_B, 2'b00,
                             TSI_F, TSF_F, pkt_cnt_q, hdr_size};
                end
                S_SID: begin
                    m_vld = 1'b1;
                    m_dat = streamID;
                end
                S_TSI: begin
                    m_vld = 1'b1;
                    m_dat = tsec_q;
                end
                S_TSF0: begin
                    m_vld = 1'b1;
                    m_dat = tfsec_q[63:32];
                end
                S_TSF1: begin
                    m_vld = 1'b1;
                    m_dat = tfsec_q[31:0];
                end
                S_PAY: begin
                    m_vld = hold_v_q;
                    m_dat = hold_q;
                    m_lst = !TRL_B && pay_end;
                end
                S_TRL: begin
                    m_vld = 1'b1;
                    m_dat = trl_q;
                    m_lst = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign m_fire = m_vld && m_axis.TREADY;
    assign drain  = m_fire && (pass || (state_q == S_PAY));
    assign s_rdy  = !hold_v_q || drain;
    assign s_fire = s_axis.TVALID && s_rdy;

    assign s_axis.TREADY = s_rdy;
    assign m_axis.TVALID = m_vld;
    assign m_axis.TDATA  = m_dat;
    assign m_axis.TLAST  = m_lst;

    assign status = {16'b0, pkts_sent_q, 5'b0, cfg_err_q, busy, done};

    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN || rcmd) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            hold_v_q     <= 1'b0;
            hold_l_q     <= 1'b0;
            pay_cnt_q    <= '0;
            pay_lim_q    <= '0;
            last_pkt_q   <= 1'b0;
            words_sent_q <= '0;
            pkt_cnt_q    <= '0;
            pkts_sent_q  <= '0;
            cfg_err_q    <= 1'b0;
            stop_q       <= 1'b0;
            tsec_q       <= '0;
            tfsec_q      <= '0;
            trl_q        <= '0;
        end else begin
            if (s_fire) begin
                hold_q   <= s_axis.TDATA;
                hold_l_q <= s_axis.TLAST;
                hold_v_q <= 1'b1;
            end else if (drain) begin
                hold_v_q <= 1'b0;
            end
            // Passthrough freezes the framing state entirely.
            if (!pass) begin
                if (busy && stop) stop_q <= 1'b1;
                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (pkt_size <= OVH) begin
                                cfg_err_q <= 1'b1;
                            end else begin
                                cfg_err_q    <= 1'b0;
                                words_sent_q <= '0;
                                state_q      <= S_HDR;
                            end
                        end
                    end
                    S_HDR: begin
                        if (m_fire) begin
                            tsec_q     <= timestamp_sec;
                            tfsec_q    <= timestamp_fsec;
                            trl_q      <= trailer_in;
                            pay_cnt_q  <= '0;
                            pay_lim_q  <= last_now ? 16'(rem) : pay_max;
                            last_pkt_q <= last_now;
                            state_q    <= S_SID;
                        end
                    end
                    S_SID:  if (m_fire) state_q <= after_sid;
                    S_TSI:  if (m_fire) state_q <= after_tsi;
                    S_TSF0: if (m_fire) state_q <= S_TSF1;
                    S_TSF1: if (m_fire) state_q <= S_PAY;
                    S_PAY: begin
                        if (m_fire) begin
                            pay_cnt_q    <= pay_cnt_q + 16'd1;
                            words_sent_q <= words_sent_q + 1'b1;
                            if (pay_end) begin
                                if (TRL_B) begin
                                    state_q <= S_TRL;
                                end else begin
                                    pkt_cnt_q   <= pkt_cnt_q + 4'd1;
                                    pkts_sent_q <= pkts_sent_q + 8'd1;
                                    state_q     <= pkt_stop ? S_DONE : S_HDR;
                                end
                            end
                        end
                    end
                    S_TRL: begin
                        if (m_fire) begin
                            pkt_cnt_q   <= pkt_cnt_q + 4'd1;
                            pkts_sent_q <= pkts_sent_q + 8'd1;
                            state_q     <= pkt_stop ? S_DONE : S_HDR;
                        end
                    end
                    S_DONE: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vita49_framer.sv
// Directed and randomized bench for vita49_framer with a packet-level
// reference model built from the framing rules.
module tb_vita49_framer;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        sel;
    logic [31:0] s_dat;
    logic        s_vld, s_lst, m_rdy;
    logic [31:0] ctrl, sid, trl, tsec, wtp;
    logic [63:0] tfsec;
    logic [15:0] psize;
    logic [31:0] c0, c1, st0, st1;

    vita49_framer_if s0 ();
    vita49_framer_if m0 ();
    vita49_framer_if s1 ();
    vita49_framer_if m1 ();

    assign s0.TDATA  = s_dat;
    assign s0.TVALID = s_vld & ~sel;
    assign s0.TLAST  = s_lst;
    assign m0.TREADY = m_rdy;
    assign s1.TDATA  = s_dat;
    assign s1.TVALID = s_vld & sel;
    assign s1.TLAST  = s_lst;
    assign m1.TREADY = m_rdy;
    assign c0 = sel ? 32'd0 : ctrl;
    assign c1 = sel ? ctrl : 32'd0;

    vita49_framer u0 (
        .AXIS_ACLK(clk), .AXIS_ARESETN(rstn),
        .s_axis(s0), .m_axis(m0),
        .ctrl(c0), .status(st0), .streamID(sid),
        .pkt_size(psize), .words_to_pack(wtp),
        .trailer_in(trl), .timestamp_sec(tsec),
        .timestamp_fsec(tfsec)
    );

    vita49_framer #(.TSI_EN(0), .TSF_EN(0), .TRL_EN(1)) u1 (
        .AXIS_ACLK(clk), .AXIS_ARESETN(rstn),
        .s_axis(s1), .m_axis(m1),
        .ctrl(c1), .status(st1), .streamID(sid),
        .pkt_size(psize), .words_to_pack(wtp),
        .trailer_in(trl), .timestamp_sec(tsec),
        .timestamp_fsec(tfsec)
    );

    logic        o_vld, o_lst, o_rdy;
    logic [31:0] o_dat, o_st;
    assign o_vld = sel ? m1.TVALID : m0.TVALID;
    assign o_lst = sel ? m1.TLAST  : m0.TLAST;
    assign o_dat = sel ? m1.TDATA  : m0.TDATA;
    assign o_rdy = sel ? s1.TREADY : s0.TREADY;
    assign o_st  = sel ? st1 : st0;

    logic [32:0] out_q[$];
    logic [31:0] ts_s_q[$];
    logic [63:0] ts_f_q[$];
    logic [31:0] pay_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    bit          running;
    bit          abort;

    // Every output transfer is logged with the timestamp inputs it saw.
    always @(negedge clk) begin
        if (rstn && o_vld && m_rdy) begin
            out_q.push_back({o_lst, o_dat});
            ts_s_q.push_back(tsec);
            ts_f_q.push_back(tfsec);
        end
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        out_q.delete();
        ts_s_q.delete();
        ts_f_q.delete();
    endtask

    task automatic fill_pay(int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back($urandom);
    endtask

    task automatic pulse(logic [31:0] v);
        ctrl = v;
        step(1);
        ctrl = 32'd0;
    endtask

    task automatic drive_in(int n, bit rnd);
        int  guard;
        bit  acc;
        guard = 0;
        for (int i = 0; i < n; i++) begin
            s_dat = pay_q[i];
            s_lst = (i == n - 1);
            acc   = 1'b0;
            while (!acc && !abort && guard < 4000) begin
                s_vld = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                @(negedge clk);
                acc = s_vld && o_rdy;
                @(posedge clk);
                #1;
                guard++;
            end
            if (abort || guard >= 4000) break;
        end
        s_vld = 1'b0;
        s_lst = 1'b0;
    endtask

    task automatic drive_rdy(bit rnd);
        while (running) begin
            m_rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd) begin
                tsec  = $urandom;
                tfsec = {$urandom, $urandom};
            end
            step(1);
        end
        m_rdy = 1'b1;
    endtask

    task automatic wait_done(string tag, int bound);
        int c;
        c = 0;
        while (!o_st[0] && c < bound) begin
            step(1);
            c++;
        end
        chk({tag, "_done"}, 64'(o_st[0]), 64'd1);
    endtask

    // Expected stream derived from packet rules, not from the RTL states.
    task automatic check_stream(string tag, int ps, int wp,
                                int hdr, int te, int tsi, int tsf);
        logic [32:0] e[$];
        logic [32:0] tmp;
        logic [31:0] tsv;
        logic [63:0] tfv;
        logic [15:0] sz;
        int          p, sent, pc, h, n;
        p = ps - hdr - te;
        sent = 0;
        pc = 0;
        while (sent < wp) begin
            n   = (wp - sent < p) ? (wp - sent) : p;
            sz  = 16'(hdr + te + n);
            h   = e.size();
            tsv = (h < ts_s_q.size()) ? ts_s_q[h] : 32'd0;
            tfv = (h < ts_f_q.size()) ? ts_f_q[h] : 64'd0;
            e.push_back({1'b0, 4'b0001, 1'b0, 1'(te), 2'b00,
                         (tsi != 0) ? 2'b11 : 2'b00,
                         (tsf != 0) ? 2'b01 : 2'b00, 4'(pc), sz});
            e.push_back({1'b0, sid});
            if (tsi != 0) e.push_back({1'b0, tsv});
            if (tsf != 0) begin
                e.push_back({1'b0, tfv[63:32]});
                e.push_back({1'b0, tfv[31:0]});
            end
            for (int i = 0; i < n; i++) e.push_back({1'b0, pay_q[sent + i]});
            if (te != 0) e.push_back({1'b0, trl});
            tmp = e.pop_back();
            tmp[32] = 1'b1;
            e.push_back(tmp);
            sent += n;
            pc++;
        end
        chk({tag, "_len"}, 64'(out_q.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < out_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(out_q[i]), 64'(e[i]));
    endtask

    task automatic run(string tag, bit s, int ps, int wp, bit rnd,
                       int hdr, int te, int tsi, int tsf);
        sel   = s;
        psize = 16'(ps);
        wtp   = 32'(wp);
        pulse(32'h2);
        step(1);
        clear_q();
        fill_pay(wp);
        pulse(32'h1);
        running = 1'b1;
        abort   = 1'b0;
        fork
            drive_in(wp, rnd);
            drive_rdy(rnd);
            begin
                wait_done(tag, 4000);
                running = 1'b0;
            end
        join
        step(2);
        check_stream(tag, ps, wp, hdr, te, tsi, tsf);
        chk({tag, "_busy"}, 64'(o_st[1]), 64'd0);
    endtask

    initial begin
        int nl, c, ps, wp;
        rstn = 1'b0; sel = 1'b0; s_dat = '0; s_vld = 1'b0; s_lst = 1'b0;
        m_rdy = 1'b1; ctrl = '0; sid = 32'hC0DE_0042; trl = 32'h7E57_A11E;
        tsec = 32'h6000_0001; tfsec = 64'h0123_4567_89AB_CDEF;
        wtp = '0; psize = 16'd9; running = 1'b0; abort = 1'b0;
        step(3);
        chk("rst_vld", 64'(m0.TVALID), 64'd0);
        chk("rst_lst", 64'(m0.TLAST), 64'd0);
        chk("rst_dat", 64'(m0.TDATA), 64'd0);
        chk("rst_st0", 64'(st0), 64'd0);
        chk("rst_st1", 64'(st1), 64'd0);
        rstn = 1'b1;
        step(1);
        chk("rst_rdy", 64'(s0.TREADY), 64'd1);

        run("s1", 1'b0, 9, 8, 1'b0, 5, 0, 1, 1);
        chk("s1_pkts", 64'(o_st[15:8]), 64'd2);
        run("s2", 1'b0, 9, 6, 1'b0, 5, 0, 1, 1);
        run("s3", 1'b1, 5, 4, 1'b0, 2, 1, 0, 0);
        chk("s3_pkts", 64'(o_st[15:8]), 64'd2);
        for (int k = 0; k < 3; k++) begin
            ps = $urandom_range(6, 12);
            wp = $urandom_range(5, 25);
            run($sformatf("s4r%0d", k), 1'b0, ps, wp, 1'b1, 5, 0, 1, 1);
        end
        run("s4t", 1'b1, $urandom_range(4, 8), $urandom_range(5, 15),
            1'b1, 2, 1, 0, 0);

        sel = 1'b0;
        pulse(32'h2);
        psize = 16'd4;
        clear_q();
        pulse(32'h1);
        step(2);
        chk("s5_cfgerr", 64'(o_st[2]), 64'd1);
        chk("s5_busy", 64'(o_st[1]), 64'd0);
        chk("s5_vld", 64'(o_vld), 64'd0);
        chk("s5_out", 64'(out_q.size()), 64'd0);

        pulse(32'h2);
        psize = 16'd20;
        wtp = '0;
        clear_q();
        fill_pay(20);
        pulse(32'h1);
        abort = 1'b0;
        fork
            drive_in(20, 1'b0);
        join_none
        c = 0;
        while (out_q.size() < 8 && c < 200) begin
            step(1);
            c++;
        end
        chk("s6_progress", 64'(out_q.size() >= 8), 64'd1);
        abort = 1'b1;
        step(2);
        pulse(32'h2);
        chk("s6_busy", 64'(o_st[1]), 64'd0);
        chk("s6_vld", 64'(o_vld), 64'd0);
        chk("s6_rdy", 64'(o_rdy), 64'd1);
        chk("s6_pkts", 64'(o_st[15:8]), 64'd0);
        nl = 0;
        foreach (out_q[i]) if (out_q[i][32]) nl++;
        chk("s6_nolast", 64'(nl), 64'd0);

        psize = 16'd9;
        clear_q();
        fill_pay(5);
        abort = 1'b0;
        pulse(32'h1);
        ctrl = 32'h8;
        fork
            drive_in(5, 1'b0);
            wait_done("s6s", 500);
        join
        ctrl = 32'h0;
        step(2);
        check_stream("s6s", 9, 4, 5, 0, 1, 1);
        chk("s6s_pkts", 64'(o_st[15:8]), 64'd1);

        pulse(32'h2);
        clear_q();
        fill_pay(3);
        ctrl = 32'h4;
        drive_in(3, 1'b0);
        step(3);
        ctrl = 32'h0;
        chk("pt_len", 64'(out_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < out_q.size(); i++)
            chk($sformatf("pt_w%0d", i), 64'(out_q[i]),
                64'({(i == 2), pay_q[i]}));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
